time2stamp: RTL and testbench

//  Converts a BCD calendar date/time (UTC) into a 64-bit Unix timestamp; the inverse of the clock's stamp-to-BCD path.

---
 rtl/time2stamp.sv | 200 ++++++++++++++++++++
 tb/tb_time2stamp.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time2stamp.sv
// time2stamp: converts a BCD calendar date/time (UTC) into a 64-bit Unix
// timestamp. The datapath is iterative: it walks one year per cycle and then
// one month per cycle, accumulating whole days, and finishes with a single
// seconds multiply-add. A start/done handshake frames each conversion.
// Optional feature: define TIME2STAMP_WEEKDAY_EN to add the weekday output
// (0=Sun..6=Sat), which is computed from the same day count as the stamp.
module time2stamp #(
  parameter int unsigned MAX_YEAR = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] year_bcd,
  input  logic [7:0]  month_bcd,
  input  logic [7:0]  day_bcd,
  input  logic [7:0]  hour_bcd,
  input  logic [7:0]  minute_bcd,
  input  logic [7:0]  second_bcd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] stamp
`ifdef TIME2STAMP_WEEKDAY_EN
  ,
  output logic [2:0]  weekday
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_YEAR  = 3'd2;
  localparam logic [2:0] ST_MONTH = 3'd3;
  localparam logic [2:0] ST_SEC   = 3'd4;

  localparam logic [15:0] MAX_YEAR_C = 16'(MAX_YEAR);

  function automatic logic nib_ok(input logic [3:0] n);
    return (n <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd2_bin(input logic [7:0] b);
    return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
  endfunction

  function automatic logic [15:0] bcd4_bin(input logic [15:0] b);
    return ({12'd0, b[15:12]} * 16'd1000) + ({12'd0, b[11:8]} * 16'd100) +
           ({12'd0, b[7:4]} * 16'd10) + {12'd0, b[3:0]};
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    return (y[1:0] == 2'd0) &&
           (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
  endfunction

  function automatic logic [4:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
    logic [4:0] d;
    case (m)
      8'd2:                    d = 5'd28 + {4'd0, is_leap(y)};
      8'd4, 8'd6, 8'd9, 8'd11: d = 5'd30;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // Latched request and iteration state
  logic [2:0]  state_r;
  logic [15:0] year_r;
  logic [7:0]  month_r, day_r, hour_r, minute_r, second_r;
  logic [21:0] days_r;
  logic [15:0] yi_r;
  logic [7:0]  mi_r;

  // Binary views of the latched BCD fields; only trusted once digits_ok_s holds
  logic [15:0] y_bin_s;
  logic [7:0]  m_bin_s, d_bin_s, h_bin_s, n_bin_s, s_bin_s;
  logic        digits_ok_s;
  logic        valid_s;
  logic [21:0] total_days_s;
  logic [16:0] sec_of_day_s;
  logic [37:0] secs_s;

  assign y_bin_s = bcd4_bin(year_r);
  assign m_bin_s = bcd2_bin(month_r);
  assign d_bin_s = bcd2_bin(day_r);
  assign h_bin_s = bcd2_bin(hour_r);
  assign n_bin_s = bcd2_bin(minute_r);
  assign s_bin_s = bcd2_bin(second_r);

  assign digits_ok_s = nib_ok(year_r[15:12]) && nib_ok(year_r[11:8]) &&
                       nib_ok(year_r[7:4])   && nib_ok(year_r[3:0])  &&
                       nib_ok(month_r[7:4])  && nib_ok(month_r[3:0]) &&
                       nib_ok(day_r[7:4])    && nib_ok(day_r[3:0])   &&
                       nib_ok(hour_r[7:4])   && nib_ok(hour_r[3:0])  &&
                       nib_ok(minute_r[7:4]) && nib_ok(minute_r[3:0]) &&
                       nib_ok(second_r[7:4]) && nib_ok(second_r[3:0]);

  assign valid_s = digits_ok_s &&
                   (y_bin_s >= 16'd1970) && (y_bin_s <= MAX_YEAR_C) &&
                   (m_bin_s >= 8'd1) && (m_bin_s <= 8'd12) &&
                   (d_bin_s >= 8'd1) &&
                   (d_bin_s <= {3'd0, days_in_month(m_bin_s, y_bin_s)}) &&
                   (h_bin_s <= 8'd23) && (n_bin_s <= 8'd59) && (s_bin_s <= 8'd59);

  // Day index of the requested date counted from 1970-01-01 (day 0)
  assign total_days_s = days_r + {14'd0, d_bin_s} - 22'd1;
  assign sec_of_day_s = ({9'd0, h_bin_s} * 17'd3600) + ({9'd0, n_bin_s} * 17'd60) +
                        {9'd0, s_bin_s};
  assign secs_s       = ({16'd0, total_days_s} * 38'd86400) + {21'd0, sec_of_day_s};

`ifdef TIME2STAMP_WEEKDAY_EN
  // 1970-01-01 was a Thursday, hence the +4 offset
  logic [21:0] wd_full_s;
  assign wd_full_s = (total_days_s + 22'd4) % 22'd7;
`endif

  assign busy = (state_r != ST_IDLE);

  // Conversion sequencer: latch, validate, walk years, walk months, emit result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      year_r   <= 16'd0;
      month_r  <= 8'd0;
      day_r    <= 8'd0;
      hour_r   <= 8'd0;
      minute_r <= 8'd0;
      second_r <= 8'd0;
      days_r   <= 22'd0;
      yi_r     <= 16'd0;
      mi_r     <= 8'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      stamp    <= 64'd0;
`ifdef TIME2STAMP_WEEKDAY_EN
      weekday  <= 3'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            year_r   <= year_bcd;
            month_r  <= month_bcd;
            day_r    <= day_bcd;
            hour_r   <= hour_bcd;
            minute_r <= minute_bcd;
            second_r <= second_bcd;
            err      <= 1'b0;
            state_r  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!valid_s) begin
            done    <= 1'b1;
            err     <= 1'b1;
            stamp   <= 64'd0;
`ifdef TIME2STAMP_WEEKDAY_EN
            weekday <= 3'd0;
`endif
            state_r <= ST_IDLE;
          end else begin
            days_r  <= 22'd0;
            yi_r    <= 16'd1970;
            state_r <= ST_YEAR;
          end
        end
        ST_YEAR: begin
          if (yi_r == y_bin_s) begin
            mi_r    <= 8'd1;
            state_r <= ST_MONTH;
          end else begin
            days_r <= days_r + 22'd365 + {21'd0, is_leap(yi_r)};
            yi_r   <= yi_r + 16'd1;
          end
        end
        ST_MONTH: begin
          if (mi_r == m_bin_s) begin
            state_r <= ST_SEC;
          end else begin
            days_r <= days_r + {17'd0, days_in_month(mi_r, y_bin_s)};
            mi_r   <= mi_r + 8'd1;
          end
        end
        ST_SEC: begin
          stamp   <= {26'd0, secs_s};
`ifdef TIME2STAMP_WEEKDAY_EN
          weekday <= wd_full_s[2:0];
`endif
          done    <= 1'b1;
          err     <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time2stamp.sv
// Self-checking bench for time2stamp: a scoreboard queue holds the expected
// stamp/err/weekday/done-cycle of each request; a monitor pops and compares
// whenever done pulses. Expected values come from spec constants or from a
// closed-form civil-date model independent of the DUT's iteration.
module tb_time2stamp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] year_bcd = 16'd0;
  logic [7:0]  month_bcd = 8'd0, day_bcd = 8'd0, hour_bcd = 8'd0;
  logic [7:0]  minute_bcd = 8'd0, second_bcd = 8'd0;
  logic        busy, done, err;
  logic [63:0] stamp;
`ifdef TIME2STAMP_WEEKDAY_EN
  logic [2:0]  weekday;
`endif

  time2stamp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .year_bcd   (year_bcd),
    .month_bcd  (month_bcd),
    .day_bcd    (day_bcd),
    .hour_bcd   (hour_bcd),
    .minute_bcd (minute_bcd),
    .second_bcd (second_bcd),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .stamp      (stamp)
`ifdef TIME2STAMP_WEEKDAY_EN
    ,
    .weekday    (weekday)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned stamp;
    bit              err;
    int              wd;
    int              cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   done_cnt = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit m_leap(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int m_dim(input int m, input int y);
    if (m == 2) return m_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // days since 1970-01-01, closed-form civil algorithm
  function automatic longint m_days(input int y, input int m, input int d);
    int yy, era, yoe, mp, doy, doe;
    yy  = (m <= 2) ? y - 1 : y;
    era = yy / 400;
    yoe = yy - era * 400;
    mp  = (m > 2) ? m - 3 : m + 9;
    doy = (153 * mp + 2) / 5 + d - 1;
    doe = yoe * 365 + yoe / 4 - yoe / 100 + doy;
    return longint'(era) * 146097 + longint'(doe) - 719468;
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd4(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk_cnt++;
        if (stamp !== mon_e.stamp) $display("FAIL stamp: got %0d, required %0d", stamp, mon_e.stamp);
        else pass_cnt++;
        chk_cnt++;
        if (err !== mon_e.err) $display("FAIL err: got %0b, required %0b", err, mon_e.err);
        else pass_cnt++;
        chk_cnt++;
        if (cyc !== mon_e.cyc) $display("FAIL latency: done at cycle %0d, required %0d", cyc, mon_e.cyc);
        else pass_cnt++;
`ifdef TIME2STAMP_WEEKDAY_EN
        chk_cnt++;
        if (int'(weekday) !== mon_e.wd) $display("FAIL weekday: got %0d, required %0d", weekday, mon_e.wd);
        else pass_cnt++;
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] yb, input logic [7:0] mb, input logic [7:0] db,
                      input logic [7:0] hb, input logic [7:0] nb, input logic [7:0] sb,
                      input longint unsigned es, input bit ee, input int ew, input int lat);
    exp_t e;
    @(posedge clk); #1;
    year_bcd = yb; month_bcd = mb; day_bcd = db;
    hour_bcd = hb; minute_bcd = nb; second_bcd = sb;
    start = 1'b1;
    start_cyc = cyc;
    e.stamp = es; e.err = ee; e.wd = ew; e.cyc = start_cyc + lat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_date(input int y, input int m, input int d, input int h, input int n, input int s);
    bit ok;
    longint dd;
    ok = (y >= 1970) && (y <= 9999) && (m >= 1) && (m <= 12) && (d >= 1) &&
         (d <= m_dim(m, y)) && (h <= 23) && (n <= 59) && (s <= 59);
    if (ok) begin
      dd = m_days(y, m, d);
      send(to_bcd4(y), to_bcd2(m), to_bcd2(d), to_bcd2(h), to_bcd2(n), to_bcd2(s),
           longint'(dd * 86400 + h * 3600 + n * 60 + s), 1'b0, int'((dd + 4) % 7),
           4 + (y - 1970) + m);
    end else begin
      send(to_bcd4(y), to_bcd2(m), to_bcd2(d), to_bcd2(h), to_bcd2(n), to_bcd2(s),
           64'd0, 1'b1, 0, 2);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0 || busy) begin
      chk_cnt++;
      $display("FAIL wait_idle: timeout with %0d results pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({busy, done, err} !== 3'b000 || stamp !== 64'd0)
      $display("FAIL reset_state: busy/done/err=%b stamp=%0d, required 000 and 0", {busy, done, err}, stamp);
    else pass_cnt++;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_spec_vectors();
    send(16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 64'd0, 1'b0, 4, 5);
    wait_idle(200);
    send(16'h2000, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56, 64'd951827696, 1'b0, 2, 36);
    wait_idle(200);
    send(16'h2038, 8'h01, 8'h19, 8'h03, 8'h14, 8'h08, 64'd2147483648, 1'b0, 2, 73);
    wait_idle(200);
    send_date(9999, 12, 31, 23, 59, 59);
    wait_idle(10000);
  endtask

  task automatic test_errors();
    send(16'h2100, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 64'd0, 1'b1, 0, 2);
    wait_idle(50);
    send(16'h2001, 8'h01, 8'h01, 8'h00, 8'h00, 8'h5A, 64'd0, 1'b1, 0, 2);
    wait_idle(50);
    send(16'h2001, 8'h01, 8'h01, 8'h24, 8'h00, 8'h00, 64'd0, 1'b1, 0, 2);
    wait_idle(50);
    send(16'h1969, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 64'd0, 1'b1, 0, 2);
    wait_idle(50);
    send(16'h2001, 8'h13, 8'h01, 8'h00, 8'h00, 8'h00, 64'd0, 1'b1, 0, 2);
    wait_idle(50);
    send(16'h2023, 8'h04, 8'h31, 8'h00, 8'h00, 8'h00, 64'd0, 1'b1, 0, 2);
    wait_idle(50);
    send(16'h1A00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 64'd0, 1'b1, 0, 2);
    wait_idle(50);
    // err must drop as soon as the next request is accepted
    send_date(1971, 1, 1, 0, 0, 1);
    @(negedge clk);
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL err_clear_on_start: got %0b, required 0", err);
    else pass_cnt++;
    wait_idle(200);
  endtask

  task automatic test_ignore_busy();
    int d0;
    d0 = done_cnt;
    send_date(2024, 6, 15, 1, 2, 3);
    repeat (5) begin @(posedge clk); #1; end
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_inflight: got %0b, required 1", busy);
    else pass_cnt++;
    year_bcd = 16'h1970; month_bcd = 8'h01; day_bcd = 8'h01;
    hour_bcd = 8'h00; minute_bcd = 8'h00; second_bcd = 8'h00;
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_idle(300);
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL ignore_busy: %0d done pulses, required 1", done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    send(16'h2024, 8'h06, 8'h15, 8'h00, 8'h00, 8'h00, 64'd1718409600, 1'b0, 6, 64);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk_cnt++;
    if ({busy, done, err} !== 3'b000 || stamp !== 64'd0)
      $display("FAIL mid_reset_state: busy/done/err=%b stamp=%0d, required 000 and 0", {busy, done, err}, stamp);
    else pass_cnt++;
    repeat (80) @(posedge clk);
    #1;
    chk_cnt++;
    if (done_cnt !== d0) $display("FAIL mid_reset_no_done: %0d done pulses, required 0", done_cnt - d0);
    else pass_cnt++;
    send(16'h2024, 8'h06, 8'h15, 8'h00, 8'h00, 8'h00, 64'd1718409600, 1'b0, 6, 64);
    wait_idle(300);
  endtask

  task automatic test_back_to_back();
    int ca;
    // valid followed by valid, second start in the done cycle of the first
    send_date(1999, 12, 31, 23, 59, 59);
    ca = start_cyc;
    while (cyc < ca + (4 + 29 + 12) - 1) begin @(posedge clk); #1; end
    send_date(1970, 3, 1, 0, 0, 0);
    chk_cnt++;
    if (start_cyc !== ca + 45) $display("FAIL b2b_align: start at %0d, required %0d", start_cyc, ca + 45);
    else pass_cnt++;
    wait_idle(300);
    // error followed immediately by a valid request
    send(16'h2001, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 64'd0, 1'b1, 0, 2);
    ca = start_cyc;
    while (cyc < ca + 1) begin @(posedge clk); #1; end
    send_date(1972, 2, 29, 6, 7, 8);
    wait_idle(300);
  endtask

  task automatic test_random();
    int y, m, d;
    for (int i = 0; i < 6; i++) begin
      y = $urandom_range(2060, 1970);
      m = $urandom_range(12, 1);
      d = $urandom_range(m_dim(m, y), 1);
      send_date(y, m, d, $urandom_range(23, 0), $urandom_range(59, 0), $urandom_range(59, 0));
      wait_idle(300);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_errors();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
